// File: rtl/video_pkg.sv
// Shared video timing constants and read-engine state encoding for the frame buffer.
// Defaults describe the 640x480 RGB444 display path.
package video_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int PIXEL_WIDTH  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    ABORT  = 2'd3
  } rd_state_e;

  // Counter width helper that never collapses to zero bits for degenerate sizes.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuf_reader_rd_pipe.sv
// BRAM read-return pipeline: carries issue-time valid/sof/eol tags alongside the
// fixed BRAM latency, then registers the returning pixel into the FIFO write port.
module rd_pipe
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  sof_tag,
  input  logic                  eol_tag,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy
);

  logic [RD_LATENCY-1:0] vld;
  logic [RD_LATENCY-1:0] sof_sr;
  logic [RD_LATENCY-1:0] eol_sr;

  // Stage RD_LATENCY-1 lines up with the cycle the BRAM presents the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      sof_sr <= '0;
      eol_sr <= '0;
      wr     <= 1'b0;
      wdata  <= '0;
      sof    <= 1'b0;
      eol    <= 1'b0;
    end else begin
      vld[0]    <= rd;
      sof_sr[0] <= rd & sof_tag;
      eol_sr[0] <= rd & eol_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i]    <= vld[i-1];
        sof_sr[i] <= sof_sr[i-1];
        eol_sr[i] <= eol_sr[i-1];
      end
      wr  <= vld[RD_LATENCY-1];
      sof <= vld[RD_LATENCY-1] & sof_sr[RD_LATENCY-1];
      eol <= vld[RD_LATENCY-1] & eol_sr[RD_LATENCY-1];
      if (vld[RD_LATENCY-1]) begin
        wdata <= rdata;
      end
    end
  end

  assign busy = |vld;

endmodule

// File: rtl/framebuf_reader.sv
// Raster-order reader of the BRAM frame store feeding the pixel output FIFO.
// Frames start only on a rising display request; almost-full throttles read issue.
module framebuf_reader #(
  parameter int DATA_WIDTH = video_pkg::PIXEL_WIDTH,
  parameter int H_ACTIVE   = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = video_pkg::V_ACTIVE,
  parameter int BRAM_DEPTH = video_pkg::FRAME_PIXELS,
  parameter int RD_LATENCY = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  output logic [$clog2(BRAM_DEPTH)-1:0] o_raddr,
  output logic                          o_rd,
  input  logic [DATA_WIDTH-1:0]         i_rdata,
  output logic                          o_wr,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic                          o_sof,
  output logic                          o_eol,
  input  logic                          i_almostfull,
  output logic                          o_busy
);

  import video_pkg::*;

  localparam int AW = $clog2(BRAM_DEPTH);
  localparam int HW = safe_clog2(H_ACTIVE);
  // Clamp to the store depth so a mis-sized frame can never address past the BRAM.
  localparam int LAST_INT = ((H_ACTIVE * V_ACTIVE) < BRAM_DEPTH) ?
                            (H_ACTIVE * V_ACTIVE) - 1 : BRAM_DEPTH - 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(LAST_INT);
  localparam logic [HW-1:0] H_LAST    = HW'(H_ACTIVE - 1);

  rd_state_e       state;
  logic [AW-1:0]   raddr;
  logic [HW-1:0]   hcnt;
  logic            req_q;
  logic            pend;
  logic            rise;
  logic            issue;
  logic            sof_tag;
  logic            eol_tag;
  logic            pipe_busy;

  assign rise    = i_req & ~req_q;
  assign issue   = (state == STREAM) & i_req & ~i_almostfull & ~i_rst;
  assign sof_tag = (raddr == '0);
  assign eol_tag = (hcnt == H_LAST);

  assign o_rd    = issue;
  assign o_raddr = raddr;
  assign o_busy  = (state != IDLE);

  // A rise in DRAIN is remembered so back-to-back frames keep their alignment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      raddr <= '0;
      hcnt  <= '0;
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= i_req;
      case (state)
        IDLE: begin
          raddr <= '0;
          hcnt  <= '0;
          if (rise || pend) begin
            state <= STREAM;
            pend  <= 1'b0;
          end
        end
        STREAM: begin
          if (!i_req) begin
            state <= ABORT;
          end else if (issue) begin
            hcnt <= (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
            if (raddr == LAST_ADDR) begin
              raddr <= '0;
              state <= DRAIN;
            end else begin
              raddr <= raddr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (rise) begin
            pend <= 1'b1;
          end
          if (!pipe_busy) begin
            state <= IDLE;
          end
        end
        ABORT: begin
          if (!pipe_busy) begin
            raddr <= '0;
            hcnt  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd      (issue),
    .sof_tag (sof_tag),
    .eol_tag (eol_tag),
    .rdata   (i_rdata),
    .wr      (o_wr),
    .wdata   (o_wdata),
    .sof     (o_sof),
    .eol     (o_eol),
    .busy    (pipe_busy)
  );

endmodule

// File: tb/tb_framebuf_reader.sv
// Directed bench for framebuf_reader on a 4x2 frame with a latency-1 BRAM model;
// every issued read pushes its expected pixel, every FIFO write pops and compares.
module tb_framebuf_reader;

  typedef struct {
    logic [11:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        af;
  logic [2:0]  raddr;
  logic        rd;
  logic [11:0] rdata;
  logic        wr;
  logic [11:0] wdata;
  logic        sof;
  logic        eol;
  logic        busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_addr = 0;
  int   wr_count = 0;
  int   sof_count = 0;
  int   eol_count = 0;
  exp_t sb[$];
  exp_t mon_e;

  framebuf_reader #(
    .DATA_WIDTH (12),
    .H_ACTIVE   (4),
    .V_ACTIVE   (2),
    .BRAM_DEPTH (8),
    .RD_LATENCY (1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_raddr      (raddr),
    .o_rd         (rd),
    .i_rdata      (rdata),
    .o_wr         (wr),
    .o_wdata      (wdata),
    .o_sof        (sof),
    .o_eol        (eol),
    .i_almostfull (af),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd) begin
      rdata <= 12'h100 + 12'(raddr);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int addr, input string tag);
    int n = 0;
    while (!(rd === 1'b1 && raddr === 3'(addr)) && n < 40) begin
      step();
      n++;
    end
    check_output(tag, (n < 40), 1);
  endtask

  // Waits for IDLE, then lets the last write reach the monitor.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check_output(tag, busy, 0);
    step();
    step();
  endtask

  task automatic new_scenario();
    exp_addr  = 0;
    wr_count  = 0;
    sof_count = 0;
    eol_count = 0;
  endtask

  // Scoreboard: pop on each FIFO write, push on each issued read.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_wr", wr, 0);
      end else begin
        mon_e = sb.pop_front();
        check_output("wdata", wdata, mon_e.data);
        check_output("sof", sof, mon_e.sof);
        check_output("eol", eol, mon_e.eol);
        wr_count++;
        if (sof === 1'b1) sof_count++;
        if (eol === 1'b1) eol_count++;
      end
    end
    if (rd === 1'b1) begin
      check_output("raddr", raddr, exp_addr);
      sb.push_back('{data: 12'(32'h100 + exp_addr), sof: (exp_addr == 0), eol: (exp_addr % 4 == 3)});
      exp_addr = (exp_addr + 1) % 8;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    af  = 1'b0;
    repeat (3) step();
    check_output("rst_raddr", raddr, 0);
    check_output("rst_rd", rd, 0);
    check_output("rst_wr", wr, 0);
    check_output("rst_wdata", wdata, 0);
    check_output("rst_sof", sof, 0);
    check_output("rst_eol", eol, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) step();

    // Basic frame: eight consecutive issues, then drain to idle.
    new_scenario();
    req = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check_output("s1_rd", rd, 1);
      check_output("s1_addr", raddr, i);
      step();
    end
    check_output("s1_drain_rd", rd, 0);
    wait_idle("s1_idle");
    check_output("s1_wr_count", wr_count, 8);
    check_output("s1_sof_count", sof_count, 1);
    check_output("s1_eol_count", eol_count, 2);
    check_output("s1_sb_empty", sb.size(), 0);
    req = 1'b0;
    repeat (2) step();

    // Backpressure for five cycles after address 2 issues.
    new_scenario();
    req = 1'b1;
    wait_issue(2, "s2_issue2");
    step();
    af = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_output("s2_stall_rd", rd, 0);
      step();
    end
    af = 1'b0;
    #1;
    check_output("s2_resume_rd", rd, 1);
    check_output("s2_resume_addr", raddr, 3);
    wait_idle("s2_idle");
    check_output("s2_wr_count", wr_count, 8);
    check_output("s2_sb_empty", sb.size(), 0);
    req = 1'b0;
    repeat (2) step();

    // Back-to-back: request re-raised during DRAIN.
    new_scenario();
    req = 1'b1;
    wait_issue(7, "s3_issue7");
    step();
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    check_output("s3_idle_busy", busy, 0);
    check_output("s3_idle_rd", rd, 0);
    step();
    check_output("s3_restart_rd", rd, 1);
    check_output("s3_restart_addr", raddr, 0);
    wait_issue(7, "s3_issue7b");
    wait_idle("s3_idle");
    check_output("s3_wr_count", wr_count, 16);
    check_output("s3_sof_count", sof_count, 2);
    check_output("s3_eol_count", eol_count, 4);
    req = 1'b0;
    repeat (2) step();

    // Abort after address 4 issues, then a fresh frame from address 0.
    new_scenario();
    req = 1'b1;
    wait_issue(4, "s4_issue4");
    step();
    req = 1'b0;
    #1;
    check_output("s4_abort_rd", rd, 0);
    wait_idle("s4_idle");
    check_output("s4_wr_count", wr_count, 5);
    check_output("s4_sb_empty", sb.size(), 0);
    exp_addr = 0;
    step();
    req = 1'b1;
    step();
    check_output("s4_restart_rd", rd, 1);
    check_output("s4_restart_addr", raddr, 0);
    wait_issue(7, "s4_issue7");
    wait_idle("s4_idle2");
    check_output("s4_wr_total", wr_count, 13);
    req = 1'b0;
    repeat (2) step();

    // Reset the cycle after address 3 issues: in-flight data is dropped.
    new_scenario();
    req = 1'b1;
    wait_issue(3, "s5_issue3");
    step();
    rst = 1'b1;
    req = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
    check_output("s5_wr", wr, 0);
    check_output("s5_rd", rd, 0);
    check_output("s5_raddr", raddr, 0);
    check_output("s5_wdata", wdata, 0);
    check_output("s5_sof", sof, 0);
    check_output("s5_eol", eol, 0);
    check_output("s5_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_output("s5_no_wr", wr, 0);
    end
    check_output("s5_wr_count", wr_count, 3);

    // Almost-full exactly when the last address is pending.
    new_scenario();
    req = 1'b1;
    wait_issue(6, "s6_issue6");
    step();
    af = 1'b1;
    #1;
    check_output("s6_hold_rd", rd, 0);
    check_output("s6_hold_addr", raddr, 7);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("s6_stall_rd", rd, 0);
      check_output("s6_stall_busy", busy, 1);
    end
    af = 1'b0;
    #1;
    check_output("s6_last_rd", rd, 1);
    check_output("s6_last_addr", raddr, 7);
    step();
    check_output("s6_drain_rd", rd, 0);
    check_output("s6_drain_busy", busy, 1);
    wait_idle("s6_idle");
    check_output("s6_wr_count", wr_count, 8);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("s6_no_restart", busy, 0);
    end
    req = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/framebuf_reader.md
Name: framebuf_reader

Overview:
- Read-side engine of the frame buffer. It scans the BRAM frame store in raster order and pushes pixels into the 125->25 MHz output FIFO.
- Frames are aligned to the display request. The FIFO almost-full flag provides backpressure.
- The block owns the BRAM read port: it issues the address and accepts read data after a fixed latency. It also tags pixels with start-of-frame and end-of-line sideband.

Parameters:
- DATA_WIDTH, 12, pixel width in bits (RGB444).
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- BRAM_DEPTH, 307200, frame store depth; must equal H_ACTIVE*V_ACTIVE.
- RD_LATENCY, 1, BRAM read latency in cycles (1 or 2).

Ports:
- i_clk  in  1  125 MHz system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  display active request, already synchronised to i_clk.
- o_raddr  out  $clog2(BRAM_DEPTH)  BRAM read address.
- o_rd  out  1  BRAM read enable.
- i_rdata  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after o_rd.
- o_wr  out  1  output FIFO write enable.
- o_wdata  out  DATA_WIDTH  output FIFO write data.
- o_sof  out  1  qualifies o_wr: pixel is address 0.
- o_eol  out  1  qualifies o_wr: pixel is the last of a line.
- i_almostfull  in  1  output FIFO almost-full flag.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high on i_clk.
  - Reset values: o_raddr=0, o_rd=0, o_wr=0, o_wdata=0, o_sof=0, o_eol=0, o_busy=0.
  - Reset also returns the FSM to IDLE and clears the in-flight pipeline, line counter and req-edge register.
- Request edge detect: req_q registers i_req; rise = i_req & ~req_q.
- FSM, four states:
  - IDLE: raddr=0, hcnt=0. On rise, go to STREAM.
  - STREAM:
    - o_rd = i_req & ~i_almostfull.
    - On each issued read, raddr increments.
    - hcnt counts 0..H_ACTIVE-1 and wraps to 0.
    - When the read at raddr==BRAM_DEPTH-1 issues, go to DRAIN.
    - If i_req falls, stop issuing the same cycle and go to ABORT.
  - DRAIN:
    - o_rd=0; wait until the in-flight pipeline is empty.
    - Then go to IDLE with raddr=0.
    - A rise seen during DRAIN is latched (pend=1). On entering IDLE with pend=1, go straight to STREAM next cycle.
  - ABORT: o_rd=0; wait until the pipeline is empty, then go to IDLE. Partial frame data already issued is still written.
- Read pipeline:
  - A valid shift register of depth RD_LATENCY carries o_rd, plus sof/eol tags computed at issue: sof=(raddr==0), eol=(hcnt==H_ACTIVE-1).
  - o_wdata is i_rdata registered one cycle.
  - o_wr, o_sof and o_eol are aligned to o_wdata.
  - Read-issue-to-o_wr latency is RD_LATENCY+1 cycles.
- Backpressure: i_almostfull gates issue only. In-flight reads always complete. The FIFO almost-full threshold must leave at least RD_LATENCY+1 free entries.
- Wrap-around:
  - raddr never exceeds BRAM_DEPTH-1.
  - The next frame always restarts at 0 only via a new rise.
  - A rise during STREAM is ignored; frame alignment is kept.
- Simultaneous events:
  - i_almostfull high on the last-address cycle: the last read is not issued, and the block stays in STREAM.
  - i_rst wins over all other events.
  - Reset mid-frame discards in-flight data: no o_wr after reset.
- Widths:
  - Address is $clog2(BRAM_DEPTH) bits unsigned; compare against BRAM_DEPTH-1 sized to the address width.
  - hcnt is $clog2(H_ACTIVE) bits.

Decomposition:
- Shared package video_pkg holds:
  - H_ACTIVE, V_ACTIVE, FRAME_PIXELS.
  - The pixel width constant.
  - FSM state localparams: IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2, ABORT=2'd3.
- One natural sub-module, rd_pipe: a parameterised RD_LATENCY valid/tag shift register and output register.
- The FSM and counters stay in the top level.

Test Plan:
- Test config for all scenarios: H_ACTIVE=4, V_ACTIVE=2, BRAM_DEPTH=8, RD_LATENCY=1; BRAM preloaded with data=addr+0x100.
1. Basic frame:
   - Stimulus: reset, then i_req high, almostfull=0.
   - Required: o_rd on 8 consecutive cycles at addr 0..7; o_wr 2 cycles after each issue with data 0x100..0x107.
   - Sideband: o_sof only on 0x100; o_eol on 0x103 and 0x107; then o_busy falls.
2. Backpressure:
   - Stimulus: assert almostfull for 5 cycles after addr 2 issues.
   - Required: no o_rd during the stall; addr 2 still written; resume at addr 3; no loss or duplication, 8 total writes.
3. Back-to-back frames:
   - Stimulus: drop i_req then raise it during DRAIN.
   - Required: pend is latched; a second frame starts at addr 0 the cycle after IDLE; o_sof asserts twice overall.
4. Abort:
   - Stimulus: drop i_req after addr 4 issues.
   - Required: writes for 0x100..0x104 only; return to IDLE; the next rise restarts at addr 0.
5. Reset mid-frame:
   - Stimulus: assert i_rst the cycle after addr 3 issues.
   - Required: o_wr=0 from the next cycle; all outputs at reset values; o_raddr=0.
6. Almostfull on last address:
   - Stimulus: almostfull high when raddr=7.
   - Required: the block holds STREAM with no issue; addr 7 issues when the flag clears, then DRAIN.
